// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester and shared-ALU bundle for alu_arbiter
interface alu_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic [2*NREQ-1:0] req_op;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_res;
  logic [3:0]        alu_a;
  logic [3:0]        alu_b;
  logic [1:0]        alu_op;
  logic [7:0]        alu_res;
  logic              busy;

  modport slave (
    input  req, req_a, req_b, req_op, alu_res,
    output gnt, rsp_valid, rsp_res, alu_a, alu_b, alu_op, busy
  );

  modport master (
    output req, req_a, req_b, req_op, alu_res,
    input  gnt, rsp_valid, rsp_res, alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - arbiter sharing one 4-bit ALU among NREQ requesters
// ALU_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round robin.
module alu4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [7:0] res
);
  always_comb begin
    res = 8'h00;
    case (op)
      2'd0:    res = {4'h0, a} + {4'h0, b};
      2'd1:    res = {4'h0, a} * {4'h0, b};
      2'd2:    res = {4'h0, a} - {4'h0, b};
      default: res = {4'h0, a & b};
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int NREQ = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0]  LAST = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE  = NREQ'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  logic [0:0]      state;
  logic [IDW-1:0]  id;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rsp_valid;
  logic [7:0]      rsp_res;
  logic [3:0]      alu_a;
  logic [3:0]      alu_b;
  logic [1:0]      alu_op;

  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  cand;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  ptr;
`endif

  // Fixed priority is the round-robin search with the pointer pinned at NREQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    cand  = LAST;
`else
    cand  = ptr;
`endif
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST) ? '0 : cand + 1'b1;
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      id        <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_res   <= 8'h00;
      alu_a     <= 4'h0;
      alu_b     <= 4'h0;
      alu_op    <= 2'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr       <= LAST;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            alu_a  <= bus.req_a[{win, 2'b00} +: 4];
            alu_b  <= bus.req_b[{win, 2'b00} +: 4];
            alu_op <= bus.req_op[{win, 1'b0} +: 2];
            gnt    <= ONE << win;
            id     <= win;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr    <= win;
`endif
            state  <= S_EXEC;
          end
        end
        default: begin
          rsp_res   <= bus.alu_res;
          rsp_valid <= ONE << id;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_res   = rsp_res;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_op    = alu_op;
  assign bus.busy      = (state == S_EXEC);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with NREQ=4
module tb_alu_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0] exp_g [4];
  logic [7:0] exp_r [4];
  logic [7:0] last_res;

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu4 u_alu (
    .a   (bus.alu_a),
    .b   (bus.alu_b),
    .op  (bus.alu_op),
    .res (bus.alu_res)
  );

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bus.req_a[4*i +: 4]  = a;
    bus.req_b[4*i +: 4]  = b;
    bus.req_op[2*i +: 2] = op;
  endtask

  initial begin
    rst        = 1'b1;
    bus.req    = '0;
    bus.req_a  = '0;
    bus.req_b  = '0;
    bus.req_op = '0;
    cyc();
    cyc();
    chk("reset_gnt", 32'(bus.gnt), 32'h0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset_rsp_res", 32'(bus.rsp_res), 32'h0);
    chk("reset_alu_a", 32'(bus.alu_a), 32'h0);
    chk("reset_alu_b", 32'(bus.alu_b), 32'h0);
    chk("reset_alu_op", 32'(bus.alu_op), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;

    set_req(0, 4'd5, 4'd3, 2'd0);
    bus.req = 4'b0001;
    cyc();
    chk("single_gnt", 32'(bus.gnt), 32'h1);
    chk("single_busy", 32'(bus.busy), 32'h1);
    chk("single_alu_a", 32'(bus.alu_a), 32'h5);
    chk("single_alu_b", 32'(bus.alu_b), 32'h3);
    chk("single_alu_op", 32'(bus.alu_op), 32'h0);
    chk("single_no_rsp_yet", 32'(bus.rsp_valid), 32'h0);
    bus.req = 4'b0000;
    cyc();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_rsp_res", 32'(bus.rsp_res), 32'h8);
    chk("single_gnt_done", 32'(bus.gnt), 32'h0);
    chk("single_busy_done", 32'(bus.busy), 32'h0);

    set_req(2, 4'd5, 4'd3, 2'd1);
    bus.req = 4'b0100;
    cyc();
    chk("mul_gnt", 32'(bus.gnt), 32'h4);
    set_req(2, 4'd5, 4'd3, 2'd2);
    cyc();
    chk("mul_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("mul_rsp_res", 32'(bus.rsp_res), 32'h0f);
    chk("mul_gnt_off", 32'(bus.gnt), 32'h0);
    cyc();
    chk("sub_gnt", 32'(bus.gnt), 32'h4);
    chk("sub_alu_op", 32'(bus.alu_op), 32'h2);
    set_req(2, 4'd5, 4'd3, 2'd3);
    cyc();
    chk("sub_rsp_res", 32'(bus.rsp_res), 32'h02);
    cyc();
    chk("and_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0000;
    cyc();
    chk("and_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("and_rsp_res", 32'(bus.rsp_res), 32'h01);

    set_req(3, 4'd9, 4'd9, 2'd3);
    bus.req = 4'b1000;
    cyc();
    chk("rst_mid_gnt", 32'(bus.gnt), 32'h8);
    chk("rst_mid_alu_a", 32'(bus.alu_a), 32'h9);
    bus.req = 4'b0000;
    rst = 1'b1;
    cyc();
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_mid_rsp_res", 32'(bus.rsp_res), 32'h0);
    chk("rst_mid_alu_a_clr", 32'(bus.alu_a), 32'h0);
    chk("rst_mid_alu_b_clr", 32'(bus.alu_b), 32'h0);
    chk("rst_mid_alu_op_clr", 32'(bus.alu_op), 32'h0);
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    chk("rst_mid_gnt_clr", 32'(bus.gnt), 32'h0);
    rst = 1'b0;
    cyc();
    chk("rst_after_rsp_valid", 32'(bus.rsp_valid), 32'h0);

    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;
    exp_r[0] = 8'd3;    exp_r[1] = 8'd4;    exp_r[2] = 8'd5;    exp_r[3] = 8'd6;
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'd2, 2'd0);
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("contend_gnt%0d", i), 32'(bus.gnt), 32'(exp_g[i]));
      bus.req[i] = 1'b0;
      cyc();
      chk($sformatf("contend_rsp_valid%0d", i), 32'(bus.rsp_valid), 32'(exp_g[i]));
      chk($sformatf("contend_rsp_res%0d", i), 32'(bus.rsp_res), 32'(exp_r[i]));
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001; exp_g[3] = 4'b0001;
    exp_r[0] = 8'h05;   exp_r[1] = 8'h05;   exp_r[2] = 8'h05;   exp_r[3] = 8'h05;
`else
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0001; exp_g[3] = 4'b0010;
    exp_r[0] = 8'h05;   exp_r[1] = 8'h10;   exp_r[2] = 8'h05;   exp_r[3] = 8'h10;
`endif
    set_req(0, 4'd7, 4'd2, 2'd2);
    set_req(1, 4'd4, 4'd4, 2'd1);
    bus.req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("fair_gnt%0d", i), 32'(bus.gnt), 32'(exp_g[i]));
      if (i == 3) bus.req = 4'b0000;
      cyc();
      chk($sformatf("fair_rsp_valid%0d", i), 32'(bus.rsp_valid), 32'(exp_g[i]));
      chk($sformatf("fair_rsp_res%0d", i), 32'(bus.rsp_res), 32'(exp_r[i]));
    end
    last_res = exp_r[3];

    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("idle_gnt%0d", i), 32'(bus.gnt), 32'h0);
      chk($sformatf("idle_rsp_valid%0d", i), 32'(bus.rsp_valid), 32'h0);
      chk($sformatf("idle_busy%0d", i), 32'(bus.busy), 32'h0);
      chk($sformatf("idle_rsp_res%0d", i), 32'(bus.rsp_res), 32'(last_res));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 4-bit combinational ALU among NREQ requesters. Each requester presents operands and an opcode with a request. The arbiter grants one requester, drives the shared ALU from registered operands, and returns the 8-bit result with a per-requester valid pulse. It sits between the ALU and the datapath clients that would otherwise each need their own ALU instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester; level, held until granted
- req_a  in  4*NREQ  operand A per requester; slice i = [4i+3:4i]
- req_b  in  4*NREQ  operand B per requester; same packing
- req_op  in  2*NREQ  opcode per requester; slice i = [2i+1:2i]
- gnt  out  NREQ  one-hot, one-cycle grant pulse; operands have been captured
- rsp_valid  out  NREQ  one-hot, one-cycle pulse; rsp_res is valid for that requester
- rsp_res  out  8  registered ALU result
- alu_a  out  4  to shared ALU operand A
- alu_b  out  4  to shared ALU operand B
- alu_op  out  2  to shared ALU opcode
- alu_res  in  8  from shared ALU result (combinational)
- busy  out  1  high while an operation is executing

## Operation
- FSM states:
  - IDLE: samples req; if any bit is set, captures the winner's a/b/op into alu_a/alu_b/alu_op, sets gnt[winner], records the winner id, and goes to EXEC. If no bit is set, stays in IDLE.
  - EXEC: lasts exactly 1 cycle and does not sample req. On the closing edge it registers rsp_res <= alu_res, sets rsp_valid[id], and returns to IDLE.
- Opcodes pass through uninterpreted: 0 add, 1 mul, 2 sub, 3 and. The 8-bit result is forwarded unchanged.
- Round robin: the pointer holds the last granted id. The search starts at pointer+1 and wraps modulo NREQ. The pointer updates on every grant.
- Requester rule: req must be deasserted by the edge that ends the gnt cycle. A req still high at the next IDLE sample counts as a new request.
- alu_a, alu_b and alu_op hold their last values in IDLE. The ALU is only observed in EXEC.
- A single requester with req held continuously is granted every 2 cycles.

## Timing
- Reset values:
  - state = IDLE, pointer = NREQ-1 (so req[0] wins first).
  - gnt = 0, rsp_valid = 0, rsp_res = 0, alu_a = alu_b = alu_op = 0, busy = 0.
- Latency with req sampled at edge k:
  - gnt and busy are high during cycle k+1.
  - rsp_valid and rsp_res are valid during cycle k+2.
- Throughput: one operation per 2 cycles. The IDLE sample at edge k+2 overlaps the rsp_valid cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers stay pending and are served in round-robin order.
- A request arriving during EXEC is not seen until the next IDLE edge.
- rsp_res holds its value until the next result. rsp_valid is never high for more than one cycle.
- Reset during EXEC:
  - The in-flight operation is discarded and no rsp_valid is produced.
  - All outputs and the pointer return to their reset values on that edge.
- Reset has priority over all other events on the same edge.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest-index asserted req always wins. The pointer register is not built. Starvation of high indices is permitted.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round robin as specified above.
- Interface and timing are identical in both builds.

## Test plan
All scenarios use the real ALU instance and NREQ=4.
- Single request: req[0], a=5, b=3, op=0 at edge k -> gnt=0001 in cycle k+1, rsp_valid=0001 and rsp_res=8 in cycle k+2.
- All opcodes from req[2] with a=5, b=3: op=1 -> 15, op=2 -> 2, op=3 -> 1. Each gnt is spaced 2 cycles apart.
- Contention: req=1111 held, with each requester dropping req after its gnt -> grant order 0,1,2,3 on cycles k+1, k+3, k+5, k+7. The fixed-priority build gives the same order here.
- Fairness: req[0] and req[1] held continuously -> grants alternate 0,1,0,1 in round robin. The fixed-priority build grants 0 every time.
- Reset mid-operation: assert rst during EXEC after a grant to req[3] -> no rsp_valid, all outputs 0. The next single req[0] is granted first.
- Idle stability: req=0 for 10 cycles -> gnt, rsp_valid and busy stay 0, and rsp_res holds its last value.
